// File: rtl/intersection_phase_ctrl_pkg.sv
// Shared types for the intersection light generator: phase/mode encodings and the night-hour test.
// Pure declarations; no state, no flow control.
package intersection_phase_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_ALLRED = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_WALK   = 3'd3,
        ST_NIGHT  = 3'd4,
        ST_EMG    = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        MODE_DAY   = 2'd0,
        MODE_NIGHT = 2'd1,
        MODE_PED   = 2'd2,
        MODE_EMG   = 2'd3
    } mode_e;

    localparam int MAX_LANES     = 8;
    localparam int HOURS_PER_DAY = 24;

    typedef logic [$clog2(MAX_LANES)-1:0] lane_idx_t;

    // Night window wraps midnight; an out-of-range hour is treated as day.
    function automatic logic night_hour(input logic [4:0] hour, input int nightStart, input int nightEnd);
        if (int'(hour) >= HOURS_PER_DAY) begin
            return 1'b0;
        end
        return (int'(hour) >= nightStart) || (int'(hour) < nightEnd);
    endfunction

endpackage

// File: rtl/intersection_phase_ctrl_rr_next_lane.sv
// Circular priority search: first lane after baseLane (wrapping, baseLane itself last) with demand.
// Purely combinational; nextLane falls back to baseLane when no lane has demand.
module rr_next_lane
    import intersection_phase_ctrl_pkg::*;
#(
    parameter int NUM_LANES = 8
) (
    input  logic [NUM_LANES-1:0]         demand,
    input  logic [$clog2(NUM_LANES)-1:0] baseLane,
    output logic [$clog2(NUM_LANES)-1:0] nextLane,
    output logic                         anyDemand
);

    localparam int LW = $clog2(NUM_LANES);

    always_comb begin
        int cand;
        nextLane  = baseLane;
        anyDemand = |demand;
        // Walk offsets from farthest to nearest so the nearest hit is written last.
        for (int off = NUM_LANES; off >= 1; off--) begin
            cand = int'(baseLane) + off;
            if (cand >= NUM_LANES) begin
                cand = cand - NUM_LANES;
            end
            if (demand[cand[LW-1:0]]) begin
                nextLane = cand[LW-1:0];
            end
        end
    end

endmodule

// File: rtl/intersection_phase_ctrl.sv
// N-lane intersection phase FSM with one shared phase timer; lamps are Moore-decoded from state.
// Phase changes take effect the cycle after the deciding edge; no backpressure, tick gates all timing.
module intersection_phase_ctrl
    import intersection_phase_ctrl_pkg::*;
#(
    parameter int NUM_LANES   = 8,
    parameter int CNT_W       = 8,
    parameter int TMR_W       = 7,
    parameter int T_GREEN     = 30,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2,
    parameter int T_WALK      = 15,
    parameter int T_EMG_MIN   = 5,
    parameter int NIGHT_START = 22,
    parameter int NIGHT_END   = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [4:0]                   hours_in,
    input  logic                         ped_req,
    input  logic                         emg_req,
    input  logic [$clog2(NUM_LANES)-1:0] emg_lane,
    input  logic [NUM_LANES*CNT_W-1:0]   lane_count,
    output logic [NUM_LANES-1:0]         green,
    output logic [NUM_LANES-1:0]         yellow,
    output logic                         walk,
    output logic [1:0]                   mode,
    output logic [$clog2(NUM_LANES)-1:0] active_lane,
    output logic                         emg_err
);

    localparam int LW = $clog2(NUM_LANES);

    phase_e               state, nextState;
    mode_e                modeQ;
    logic [TMR_W-1:0]     timer, loadVal;
    logic                 loadTimer;
    logic [LW-1:0]        activeLane, nextActive, incLane, rrLane;
    logic                 rrAny;
    logic [NUM_LANES-1:0] laneBusy, laneOh;
    logic                 pedPend, flash, emgHeld, emgErrQ;
    logic                 emgLaneOk, emgValid, isNight, expire, otherDemand;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            laneBusy[i] = |lane_count[i*CNT_W +: CNT_W];
        end
    end

    assign laneOh      = NUM_LANES'(1) << activeLane;
    assign otherDemand = |(laneBusy & ~laneOh);
    assign incLane     = (activeLane == LW'(NUM_LANES-1)) ? '0 : activeLane + 1'b1;
    assign emgLaneOk   = ({1'b0, emg_lane} < (LW+1)'(NUM_LANES));
    assign emgValid    = emg_req && emgLaneOk;
    assign isNight     = night_hour(hours_in, NIGHT_START, NIGHT_END);
    assign expire      = tick && (timer == '0);

    rr_next_lane #(
        .NUM_LANES (NUM_LANES)
    ) uRrNext (
        .demand    (laneBusy),
        .baseLane  (activeLane),
        .nextLane  (rrLane),
        .anyDemand (rrAny)
    );

    always_comb begin
        nextState  = state;
        nextActive = activeLane;
        loadTimer  = 1'b0;
        case (state)
            ST_ALLRED: begin
                if (expire) begin
                    if (emgValid) begin
                        nextState  = ST_EMG;
                        nextActive = emg_lane;
                    end else if (pedPend) begin
                        nextState = ST_WALK;
                    end else if (isNight) begin
                        nextState = ST_NIGHT;
                    end else begin
                        nextState  = ST_GREEN;
                        nextActive = rrAny ? rrLane : incLane;
                    end
                end
            end
            ST_GREEN: begin
                // Preemption of the lane already green skips clearance entirely.
                if (emgValid) begin
                    nextState = (emg_lane == activeLane) ? ST_EMG : ST_YELLOW;
                end else if (expire) begin
                    if (pedPend || isNight || otherDemand) begin
                        nextState = ST_YELLOW;
                    end else begin
                        loadTimer = 1'b1;
                    end
                end
            end
            ST_YELLOW: begin
                if (expire) nextState = ST_ALLRED;
            end
            ST_WALK: begin
                if (emgValid || expire) nextState = ST_ALLRED;
            end
            ST_NIGHT: begin
                if (emgValid || pedPend || !isNight) nextState = ST_ALLRED;
            end
            ST_EMG: begin
                if (!emgValid && (expire || emgHeld)) nextState = ST_YELLOW;
            end
            default: nextState = ST_ALLRED;
        endcase
        if (nextState != state) loadTimer = 1'b1;
    end

    always_comb begin
        case (nextState)
            ST_GREEN:  loadVal = TMR_W'(T_GREEN - 1);
            ST_YELLOW: loadVal = TMR_W'(T_YELLOW - 1);
            ST_ALLRED: loadVal = TMR_W'(T_ALLRED - 1);
            ST_WALK:   loadVal = TMR_W'(T_WALK - 1);
            ST_EMG:    loadVal = TMR_W'(T_EMG_MIN - 1);
            default:   loadVal = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ALLRED;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer      <= TMR_W'(T_ALLRED - 1);
            activeLane <= '0;
            pedPend    <= 1'b0;
            flash      <= 1'b0;
            emgHeld    <= 1'b0;
            emgErrQ    <= 1'b0;
        end else begin
            activeLane <= nextActive;
            if (loadTimer) begin
                timer <= loadVal;
            end else if (tick && timer != '0) begin
                timer <= timer - 1'b1;
            end
            // Presses during an active walk are already being served and are dropped.
            if (nextState == ST_WALK && state != ST_WALK) begin
                pedPend <= 1'b0;
            end else if (ped_req && state != ST_WALK) begin
                pedPend <= 1'b1;
            end
            flash   <= (state == ST_NIGHT && nextState == ST_NIGHT) ? (flash ^ tick) : 1'b0;
            emgHeld <= (state == ST_EMG && nextState == ST_EMG) && (emgHeld || expire);
            emgErrQ <= emg_req && (emgErrQ || !emgLaneOk);
        end
    end

    always_comb begin
        green  = '0;
        yellow = '0;
        walk   = 1'b0;
        modeQ  = MODE_DAY;
        case (state)
            ST_GREEN:  green = laneOh;
            ST_YELLOW: yellow = laneOh;
            ST_WALK: begin
                walk  = 1'b1;
                modeQ = MODE_PED;
            end
            ST_NIGHT: begin
                yellow = {NUM_LANES{flash}};
                modeQ  = MODE_NIGHT;
            end
            ST_EMG: begin
                green = laneOh;
                modeQ = MODE_EMG;
            end
            default: ;
        endcase
    end

    assign mode        = modeQ;
    assign active_lane = activeLane;
    assign emg_err     = emgErrQ;

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Directed bench for intersection_phase_ctrl: 8-lane main instance plus a 4-lane instance.
module tb_intersection_phase_ctrl;
    import intersection_phase_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        pedReq = 1'b0;
    logic        emgReq = 1'b0;
    logic [4:0]  hoursIn = 5'd12;
    lane_idx_t   emgLane = '0;
    logic [63:0] laneCount = '0;
    logic [7:0]  green, yellow;
    logic        walk, emgErr;
    logic [1:0]  mode;
    lane_idx_t   activeLane;

    logic [1:0]  emgLane4 = '0;
    logic [31:0] laneCount4 = '0;
    logic [3:0]  green4, yellow4;
    logic        walk4, emgErr4;
    logic [1:0]  mode4, activeLane4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intersection_phase_ctrl #(.NUM_LANES(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .hours_in(hoursIn), .ped_req(pedReq),
        .emg_req(emgReq), .emg_lane(emgLane), .lane_count(laneCount),
        .green(green), .yellow(yellow), .walk(walk), .mode(mode),
        .active_lane(activeLane), .emg_err(emgErr)
    );

    intersection_phase_ctrl #(.NUM_LANES(4)) dut4 (
        .clk(clk), .rst(rst), .tick(tick), .hours_in(hoursIn), .ped_req(pedReq),
        .emg_req(emgReq), .emg_lane(emgLane4), .lane_count(laneCount4),
        .green(green4), .yellow(yellow4), .walk(walk4), .mode(mode4),
        .active_lane(activeLane4), .emg_err(emgErr4)
    );

    task automatic doTick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic tickN(input int n);
        repeat (n) doTick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({green, yellow, walk, mode, activeLane, emgErr} !== 24'h0) begin errors++; $display("FAIL reset_held: got %h want 0", {green, yellow, walk, mode, activeLane, emgErr}); end
        checks++; if ({green4, yellow4, walk4, mode4, activeLane4, emgErr4} !== 14'h0) begin errors++; $display("FAIL reset_held4: got %h want 0", {green4, yellow4, walk4, mode4, activeLane4, emgErr4}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({green, yellow, walk, mode, activeLane, emgErr} !== 24'h0) begin errors++; $display("FAIL reset_release: got %h want 0", {green, yellow, walk, mode, activeLane, emgErr}); end
    endtask

    task automatic test_idle_hold();
        logic bad;
        doTick();
        checks++; if (green !== 8'h00) begin errors++; $display("FAIL idle_allred: got %h want 00", green); end
        doTick();
        checks++; if (green !== 8'h02) begin errors++; $display("FAIL idle_green: got %h want 02", green); end
        checks++; if (activeLane !== 3'd1) begin errors++; $display("FAIL idle_lane: got %0d want 1", activeLane); end
        bad = 1'b0;
        for (int i = 0; i < 29; i++) begin
            doTick();
            if (green !== 8'h02 || yellow !== 8'h00) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL idle_steady: got %b want 0", bad); end
        doTick();
        checks++; if ({green, yellow} !== 16'h0200) begin errors++; $display("FAIL idle_reload: got %h want 0200", {green, yellow}); end
    endtask

    task automatic test_round_robin();
        laneCount = 64'h0000_0000_0000_0005;
        tickN(29);
        checks++; if (green !== 8'h02) begin errors++; $display("FAIL rr_hold1: got %h want 02", green); end
        doTick();
        checks++; if ({green, yellow} !== 16'h0002) begin errors++; $display("FAIL rr_yellow1: got %h want 0002", {green, yellow}); end
        tickN(2);
        checks++; if (yellow !== 8'h02) begin errors++; $display("FAIL rr_yellow1_end: got %h want 02", yellow); end
        doTick();
        checks++; if ({green, yellow} !== 16'h0000) begin errors++; $display("FAIL rr_allred1: got %h want 0000", {green, yellow}); end
        tickN(2);
        checks++; if (green !== 8'h01) begin errors++; $display("FAIL rr_green0: got %h want 01", green); end
        laneCount = 64'h0000_0000_0200_0005;
        tickN(29);
        checks++; if (green !== 8'h01) begin errors++; $display("FAIL rr_hold0: got %h want 01", green); end
        doTick();
        checks++; if (yellow !== 8'h01) begin errors++; $display("FAIL rr_yellow0: got %h want 01", yellow); end
        tickN(3);
        checks++; if ({green, yellow} !== 16'h0000) begin errors++; $display("FAIL rr_allred0: got %h want 0000", {green, yellow}); end
        tickN(2);
        checks++; if ({green, activeLane} !== {8'h08, 3'd3}) begin errors++; $display("FAIL rr_green3: got %h/%0d want 08/3", green, activeLane); end
    endtask

    task automatic test_ped();
        tickN(10);
        pedReq = 1'b1;
        @(negedge clk);
        pedReq = 1'b0;
        tickN(19);
        checks++; if ({green, walk} !== {8'h08, 1'b0}) begin errors++; $display("FAIL ped_green_kept: got %h/%b want 08/0", green, walk); end
        doTick();
        checks++; if (yellow !== 8'h08) begin errors++; $display("FAIL ped_yellow: got %h want 08", yellow); end
        tickN(3);
        checks++; if ({green, yellow, walk} !== 17'h0) begin errors++; $display("FAIL ped_allred: got %h want 0", {green, yellow, walk}); end
        tickN(2);
        checks++; if ({walk, mode} !== {1'b1, 2'd2}) begin errors++; $display("FAIL ped_walk: got %b/%0d want 1/2", walk, mode); end
        tickN(14);
        checks++; if (walk !== 1'b1) begin errors++; $display("FAIL ped_walk_end: got %b want 1", walk); end
        doTick();
        checks++; if ({walk, mode} !== {1'b0, 2'd0}) begin errors++; $display("FAIL ped_walk_off: got %b/%0d want 0/0", walk, mode); end
        tickN(2);
        checks++; if (green !== 8'h01) begin errors++; $display("FAIL ped_next: got %h want 01", green); end
    endtask

    task automatic test_emg();
        laneCount = 64'h0000_0000_0004_0000;
        tickN(30);
        checks++; if (yellow !== 8'h01) begin errors++; $display("FAIL emg_pre_yellow: got %h want 01", yellow); end
        tickN(5);
        checks++; if (green !== 8'h04) begin errors++; $display("FAIL emg_pre_green2: got %h want 04", green); end
        tickN(5);
        emgReq = 1'b1;
        emgLane = 3'd5;
        @(negedge clk);
        checks++; if ({green, yellow} !== 16'h0004) begin errors++; $display("FAIL emg_abort: got %h want 0004", {green, yellow}); end
        tickN(5);
        checks++; if ({green, mode, activeLane} !== {8'h20, 2'd3, 3'd5}) begin errors++; $display("FAIL emg_green5: got %h/%0d/%0d want 20/3/5", green, mode, activeLane); end
        tickN(2);
        emgLane = 3'd1;
        @(negedge clk);
        checks++; if (green !== 8'h20) begin errors++; $display("FAIL emg_lane_change: got %h want 20", green); end
        emgReq = 1'b0;
        tickN(2);
        checks++; if ({green, mode} !== {8'h20, 2'd3}) begin errors++; $display("FAIL emg_min_hold: got %h/%0d want 20/3", green, mode); end
        doTick();
        checks++; if ({yellow, mode} !== {8'h20, 2'd0}) begin errors++; $display("FAIL emg_exit: got %h/%0d want 20/0", yellow, mode); end
        tickN(5);
        checks++; if ({green, activeLane} !== {8'h04, 3'd2}) begin errors++; $display("FAIL emg_resume: got %h/%0d want 04/2", green, activeLane); end
    endtask

    task automatic test_emg_same_lane();
        emgReq = 1'b1;
        emgLane = 3'd2;
        @(negedge clk);
        checks++; if ({green, yellow, mode} !== {8'h04, 8'h00, 2'd3}) begin errors++; $display("FAIL same_direct: got %h want 04003", {green, yellow, mode}); end
        emgReq = 1'b0;
        tickN(4);
        checks++; if (mode !== 2'd3) begin errors++; $display("FAIL same_hold: got %0d want 3", mode); end
        doTick();
        checks++; if (yellow !== 8'h04) begin errors++; $display("FAIL same_exit: got %h want 04", yellow); end
        tickN(5);
        checks++; if (green !== 8'h04) begin errors++; $display("FAIL same_resume: got %h want 04", green); end
    endtask

    task automatic test_back_to_back();
        pedReq = 1'b1;
        emgReq = 1'b1;
        emgLane = 3'd6;
        @(negedge clk);
        pedReq = 1'b0;
        checks++; if (yellow !== 8'h04) begin errors++; $display("FAIL b2b_yellow: got %h want 04", yellow); end
        tickN(5);
        checks++; if ({green, mode, walk} !== {8'h40, 2'd3, 1'b0}) begin errors++; $display("FAIL b2b_emg_first: got %h/%0d/%b want 40/3/0", green, mode, walk); end
        emgReq = 1'b0;
        tickN(5);
        checks++; if (yellow !== 8'h40) begin errors++; $display("FAIL b2b_emg_yellow: got %h want 40", yellow); end
        tickN(5);
        checks++; if (walk !== 1'b1) begin errors++; $display("FAIL b2b_walk: got %b want 1", walk); end
        tickN(15);
        checks++; if (walk !== 1'b0) begin errors++; $display("FAIL b2b_walk_done: got %b want 0", walk); end
        tickN(2);
        checks++; if (green !== 8'h04) begin errors++; $display("FAIL b2b_green: got %h want 04", green); end
    endtask

    task automatic test_night();
        hoursIn = 5'd21;
        tickN(10);
        hoursIn = 5'd22;
        tickN(19);
        checks++; if (green !== 8'h04) begin errors++; $display("FAIL night_green_kept: got %h want 04", green); end
        doTick();
        checks++; if (yellow !== 8'h04) begin errors++; $display("FAIL night_yellow: got %h want 04", yellow); end
        tickN(5);
        checks++; if ({green, yellow, mode} !== {16'h0000, 2'd1}) begin errors++; $display("FAIL night_enter: got %h/%h/%0d want 00/00/1", green, yellow, mode); end
        doTick();
        checks++; if (yellow !== 8'hFF) begin errors++; $display("FAIL night_flash_on: got %h want ff", yellow); end
        doTick();
        checks++; if (yellow !== 8'h00) begin errors++; $display("FAIL night_flash_off: got %h want 00", yellow); end
        doTick();
        checks++; if (yellow !== 8'hFF) begin errors++; $display("FAIL night_flash_on2: got %h want ff", yellow); end
        hoursIn = 5'd6;
        @(negedge clk);
        checks++; if ({yellow, mode} !== {8'h00, 2'd0}) begin errors++; $display("FAIL night_exit: got %h/%0d want 00/0", yellow, mode); end
        tickN(2);
        checks++; if (green !== 8'h04) begin errors++; $display("FAIL night_day_green: got %h want 04", green); end
    endtask

    task automatic test_lanes4_reset();
        rst = 1'b1;
        @(negedge clk);
        laneCount = '0;
        laneCount4 = 32'h0000_0100;
        hoursIn = 5'd12;
        emgReq = 1'b1;
        emgLane = 3'd3;
        emgLane4 = 2'd3;
        rst = 1'b0;
        tickN(2);
        checks++; if ({green4, mode4, activeLane4} !== {4'h8, 2'd3, 2'd3}) begin errors++; $display("FAIL l4_emg3: got %h/%0d/%0d want 8/3/3", green4, mode4, activeLane4); end
        checks++; if (green !== 8'h08) begin errors++; $display("FAIL l8_emg3: got %h want 08", green); end
        emgReq = 1'b0;
        tickN(5);
        checks++; if ({yellow4, yellow} !== 12'h808) begin errors++; $display("FAIL l4_yellow: got %h want 808", {yellow4, yellow}); end
        tickN(1);
        #2 rst = 1'b1;
        #1;
        checks++; if ({green4, yellow4, walk4, mode4, activeLane4} !== 13'h0) begin errors++; $display("FAIL l4_async_rst: got %h want 0", {green4, yellow4, walk4, mode4, activeLane4}); end
        checks++; if ({green, yellow, mode} !== 18'h0) begin errors++; $display("FAIL l8_async_rst: got %h want 0", {green, yellow, mode}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_hold();
        test_round_robin();
        test_ped();
        test_emg();
        test_emg_same_lane();
        test_back_to_back();
        test_night();
        test_lanes4_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
